seg_ser_drv: RTL and testbench

- Segment-side serial driver for the 6-digit multiplexed 7-segment display; it sits directly downstream of the common (digit) driver.
- Per digit it:
  - captures the 8-bit segment pattern read from display memory at the current digit address;
  - shifts the pattern out to an external 8-bit shift/latch register;
  - latches the pattern and holds the digit lit for a dwell time;
  - pulses com_cnt_en so the common driver advances to the next digit.
- All pacing uses the shared update_en tick.

---
 rtl/seg_pkg.sv | 65 ++++++
 rtl/seg_ser_drv_shifter.sv | 46 ++++
 rtl/seg_ser_drv.sv | 177 +++++++++++++++++
 tb/tb_seg_ser_drv.sv | 544 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the segment-side display driver.
//   - seg_state_e : driver FSM states
//   - NUM_DIGITS  : digits scanned by the common driver
//   - SEG_DW      : segment bits per digit (a..g, dp)
//   - SEG_OFF     : logical all-segments-off pattern (before pin polarity)
//   - GLYPH_*     : 7-segment glyphs 0-F (bit0=a .. bit6=g, bit7=dp)
//   - seg_glyph() : nibble -> glyph lookup for display-memory init
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEG_DW     = 8;

    localparam logic [SEG_DW-1:0] SEG_OFF = '0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        HOLD,
        ADV
    } seg_state_e;

    localparam logic [SEG_DW-1:0] GLYPH_0 = 8'h3F;
    localparam logic [SEG_DW-1:0] GLYPH_1 = 8'h06;
    localparam logic [SEG_DW-1:0] GLYPH_2 = 8'h5B;
    localparam logic [SEG_DW-1:0] GLYPH_3 = 8'h4F;
    localparam logic [SEG_DW-1:0] GLYPH_4 = 8'h66;
    localparam logic [SEG_DW-1:0] GLYPH_5 = 8'h6D;
    localparam logic [SEG_DW-1:0] GLYPH_6 = 8'h7D;
    localparam logic [SEG_DW-1:0] GLYPH_7 = 8'h07;
    localparam logic [SEG_DW-1:0] GLYPH_8 = 8'h7F;
    localparam logic [SEG_DW-1:0] GLYPH_9 = 8'h6F;
    localparam logic [SEG_DW-1:0] GLYPH_A = 8'h77;
    localparam logic [SEG_DW-1:0] GLYPH_B = 8'h7C;
    localparam logic [SEG_DW-1:0] GLYPH_C = 8'h39;
    localparam logic [SEG_DW-1:0] GLYPH_D = 8'h5E;
    localparam logic [SEG_DW-1:0] GLYPH_E = 8'h79;
    localparam logic [SEG_DW-1:0] GLYPH_F = 8'h71;

    function automatic logic [SEG_DW-1:0] seg_glyph(input logic [3:0] nib);
        logic [SEG_DW-1:0] g;
        case (nib)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_ser_drv_shifter.sv
// seg_shifter: parallel-load, tick-enabled shift register.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : pacing tick; register holds when low
//   load       : capture din (takes priority over shift)
//   shift      : advance one bit towards the output end
//   din        : parallel load data
//   ser_bit    : bit currently at the output end (MSB, or LSB if LSB_FIRST)
module seg_shifter
    import seg_pkg::*;
#(
    parameter int unsigned DW        = SEG_DW,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic          shift,
    input  logic [DW-1:0] din,
    output logic          ser_bit
);

    logic [DW-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (en) begin
            if (load) begin
                shreg_d = din;
            end else if (shift) begin
                shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign ser_bit = LSB_FIRST ? shreg_q[0] : shreg_q[DW-1];

endmodule

// File: rtl/seg_ser_drv.sv
// seg_ser_drv: segment-side serial driver for the multiplexed 7-segment display.
// Per digit: capture mem_rdata, shift it out to an external shift/latch
// register, latch it, hold for HOLD_TICKS update_en ticks, then pulse
// com_cnt_en so the common driver advances. All steps are paced by update_en.
//   clk, rst_n  : clock, asynchronous active-low reset
//   update_en   : pacing tick (single-cycle or continuous)
//   disp_on     : (SEG_BLANK_EN only) 0 blanks the captured pattern
//   mem_rdata   : segment pattern for the current digit address
//   seg_ser     : serial segment data
//   seg_sclk    : shift clock (external register samples on rising edge)
//   seg_rclk    : latch strobe (external latch updates on rising edge)
//   com_cnt_en  : one-tick digit-advance request to the common driver
//   busy        : high in every state except IDLE
// Optional feature: define SEG_BLANK_EN to add the disp_on blanking input.
module seg_ser_drv
    import seg_pkg::*;
#(
    parameter int unsigned DW         = SEG_DW,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          SEG_ACT    = 1'b1,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          update_en,
`ifdef SEG_BLANK_EN
    input  logic          disp_on,
`endif
    input  logic [DW-1:0] mem_rdata,
    output logic          seg_ser,
    output logic          seg_sclk,
    output logic          seg_rclk,
    output logic          com_cnt_en,
    output logic          busy
);

    localparam int unsigned    BCW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DW - 1);
    localparam logic [7:0]     HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [DW-1:0]  POL_MASK  = {DW{~SEG_ACT}};

    seg_state_e     state_q, state_d;
    logic           seg_ser_q, seg_ser_d;
    logic           seg_sclk_q, seg_sclk_d;
    logic           seg_rclk_q, seg_rclk_d;
    logic           com_cnt_en_q, com_cnt_en_d;
    logic           busy_q, busy_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]     hold_cnt_q, hold_cnt_d;

    logic [DW-1:0]  logical;
    logic [DW-1:0]  pattern;
    logic           first_bit;
    logic           sh_load;
    logic           sh_shift;
    logic           ser_bit;

    // Pattern as it must appear on the pin: optional blanking, then polarity.
    always_comb begin
`ifdef SEG_BLANK_EN
        logical = disp_on ? mem_rdata : DW'(SEG_OFF);
`else
        logical = mem_rdata;
`endif
        pattern   = logical ^ POL_MASK;
        first_bit = LSB_FIRST ? pattern[0] : pattern[DW-1];
    end

    // The shifter advances on the sclk rising step (SHIFT_LO) while seg_ser
    // is held in its own flop, so seg_ser only picks up the new head on the
    // following falling step (SHIFT_HI). The extra shift after the last bit
    // is harmless: the register is reloaded in the next LOAD.
    seg_shifter #(
        .DW        (DW),
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (update_en),
        .load    (sh_load),
        .shift   (sh_shift),
        .din     (pattern),
        .ser_bit (ser_bit)
    );

    always_comb begin
        state_d      = state_q;
        seg_ser_d    = seg_ser_q;
        seg_sclk_d   = seg_sclk_q;
        seg_rclk_d   = seg_rclk_q;
        com_cnt_en_d = com_cnt_en_q;
        busy_d       = busy_q;
        bit_cnt_d    = bit_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;

        if (update_en) begin
            unique case (state_q)
                IDLE: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    sh_load   = 1'b1;
                    seg_ser_d = first_bit;
                    bit_cnt_d = '0;
                    state_d   = SHIFT_LO;
                end
                SHIFT_LO: begin
                    seg_sclk_d = 1'b1;
                    sh_shift   = 1'b1;
                    state_d    = SHIFT_HI;
                end
                SHIFT_HI: begin
                    seg_sclk_d = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        seg_rclk_d = 1'b1;
                        state_d    = LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        seg_ser_d = ser_bit;
                        state_d   = SHIFT_LO;
                    end
                end
                LATCH: begin
                    seg_rclk_d = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end
                HOLD: begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        com_cnt_en_d = 1'b1;
                        state_d      = ADV;
                    end
                end
                ADV: begin
                    com_cnt_en_d = 1'b0;
                    state_d      = LOAD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            busy_d = (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            seg_ser_q    <= 1'b0;
            seg_sclk_q   <= 1'b0;
            seg_rclk_q   <= 1'b0;
            com_cnt_en_q <= 1'b0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            seg_ser_q    <= seg_ser_d;
            seg_sclk_q   <= seg_sclk_d;
            seg_rclk_q   <= seg_rclk_d;
            com_cnt_en_q <= com_cnt_en_d;
            busy_q       <= busy_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign seg_ser    = seg_ser_q;
    assign seg_sclk   = seg_sclk_q;
    assign seg_rclk   = seg_rclk_q;
    assign com_cnt_en = com_cnt_en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seg_ser_drv.sv
// Testbench for seg_ser_drv. Two instances share clk/rst_n/update_en:
//   dut_a : MSB first, active-high segments, HOLD_TICKS=16, fed by a model of
//           the common driver (address 0..5) and a 6-entry display memory
//   dut_b : LSB first, inverted segments, HOLD_TICKS=1, fed directly
// An external shift/latch register and the common driver are modelled here.
module tb_seg_ser_drv;
    import seg_pkg::*;

    localparam int unsigned HOLD_A = 16;
    localparam int unsigned HOLD_B = 1;
    localparam int          PER_A  = 1 + 2 * 8 + 1 + HOLD_A + 1;
    localparam int          PER_B  = 1 + 2 * 8 + 1 + HOLD_B + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic update_en = 1'b0;

    logic [7:0]  mem [NUM_DIGITS];
    logic [7:0]  mem_rdata_a;
    logic [7:0]  mem_b = 8'h00;
    logic [7:0]  glitch_val = 8'h00;
    bit          glitch_on = 1'b0;
    bit          b_rand = 1'b0;
    int unsigned addr = 0;
`ifdef SEG_BLANK_EN
    logic        disp_on = 1'b1;
`endif

    logic ser_a, sclk_a, rclk_a, com_a, busy_a;
    logic ser_b, sclk_b, rclk_b, com_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ticks remaining until the driver's next LOAD step (1 = next tick loads)
    int ttl_a = 2;
    int ttl_b = 2;

    // Memory read port; outside the LOAD tick the data may be scrambled to
    // prove that only the value present at LOAD is captured.
    assign mem_rdata_a = (glitch_on && ttl_a != 1) ? glitch_val : mem[addr];

    seg_ser_drv #(
        .DW         (8),
        .LSB_FIRST  (1'b0),
        .SEG_ACT    (1'b1),
        .HOLD_TICKS (HOLD_A)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .update_en  (update_en),
`ifdef SEG_BLANK_EN
        .disp_on    (disp_on),
`endif
        .mem_rdata  (mem_rdata_a),
        .seg_ser    (ser_a),
        .seg_sclk   (sclk_a),
        .seg_rclk   (rclk_a),
        .com_cnt_en (com_a),
        .busy       (busy_a)
    );

    seg_ser_drv #(
        .DW         (8),
        .LSB_FIRST  (1'b1),
        .SEG_ACT    (1'b0),
        .HOLD_TICKS (HOLD_B)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .update_en  (update_en),
`ifdef SEG_BLANK_EN
        .disp_on    (disp_on),
`endif
        .mem_rdata  (mem_b),
        .seg_ser    (ser_b),
        .seg_sclk   (sclk_b),
        .seg_rclk   (rclk_b),
        .com_cnt_en (com_b),
        .busy       (busy_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] visible(input logic [7:0] m);
`ifdef SEG_BLANK_EN
        return disp_on ? m : 8'h00;
`else
        return m;
`endif
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    logic [7:0] cap_a = 8'h00, cap_b = 8'h00;
    int  per_cnt_a = 0, per_cnt_b = 0;
    bit  seen_a = 1'b0, seen_b = 1'b0;
    int  q_per_a[$], q_per_b[$];
    int  na, nb;

    // Tick-level model: what each driver captures, common-driver address,
    // and the tick distance between successive advance requests.
    always @(posedge clk) begin
        if (!rst_n) begin
            addr      <= 0;
            ttl_a     <= 2;
            ttl_b     <= 2;
            per_cnt_a = 0;
            per_cnt_b = 0;
            seen_a    = 1'b0;
            seen_b    = 1'b0;
        end else if (update_en) begin
            if (ttl_a == 1) cap_a = visible(mem_rdata_a);
            if (ttl_b == 1) cap_b = visible(mem_b);
            na = (ttl_a > 0) ? ttl_a - 1 : 0;
            nb = (ttl_b > 0) ? ttl_b - 1 : 0;
            per_cnt_a++;
            per_cnt_b++;
            if (com_a) begin
                if (seen_a) q_per_a.push_back(per_cnt_a);
                per_cnt_a = 0;
                seen_a    = 1'b1;
                na        = 1;
                addr     <= (addr == NUM_DIGITS - 1) ? 0 : addr + 1;
            end
            if (com_b) begin
                if (seen_b) q_per_b.push_back(per_cnt_b);
                per_cnt_b = 0;
                seen_b    = 1'b1;
                nb        = 1;
            end
            ttl_a <= na;
            ttl_b <= nb;
        end
    end

    // External shift/latch register model, sampled away from the clock edge.
    logic [7:0] ext_a = 8'h00, ext_b = 8'h00;
    int  rise_a = 0, rise_b = 0, stab_a = 0, stab_b = 0;
    logic pv_ser_a = 1'b0, pv_sclk_a = 1'b0, pv_rclk_a = 1'b0;
    logic pv_ser_b = 1'b0, pv_sclk_b = 1'b0, pv_rclk_b = 1'b0;
    logic [7:0] q_obs_a[$], q_exp_a[$], q_obs_b[$], q_exp_b[$];
    int  q_rise_a[$], q_rise_b[$], q_addr_a[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            ext_a = 8'h00; ext_b = 8'h00; rise_a = 0; rise_b = 0;
            pv_ser_a = 1'b0; pv_sclk_a = 1'b0; pv_rclk_a = 1'b0;
            pv_ser_b = 1'b0; pv_sclk_b = 1'b0; pv_rclk_b = 1'b0;
        end else begin
            if (sclk_a && !pv_sclk_a) begin
                if (ser_a !== pv_ser_a) stab_a++;
                ext_a = {ext_a[6:0], ser_a};
                rise_a++;
            end
            if (rclk_a && !pv_rclk_a) begin
                q_obs_a.push_back(ext_a);
                q_exp_a.push_back(cap_a);
                q_rise_a.push_back(rise_a);
                q_addr_a.push_back(int'(addr));
                rise_a = 0;
            end
            if (sclk_b && !pv_sclk_b) begin
                if (ser_b !== pv_ser_b) stab_b++;
                ext_b = {ext_b[6:0], ser_b};
                rise_b++;
            end
            if (rclk_b && !pv_rclk_b) begin
                q_obs_b.push_back(ext_b);
                q_exp_b.push_back(rev8(cap_b ^ 8'hFF));
                q_rise_b.push_back(rise_b);
                rise_b = 0;
            end
            pv_ser_a = ser_a; pv_sclk_a = sclk_a; pv_rclk_a = rclk_a;
            pv_ser_b = ser_b; pv_sclk_b = sclk_b; pv_rclk_b = rclk_b;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clk_step(input bit en);
        update_en = en;
        @(posedge clk);
        #1;
        if (glitch_on) glitch_val = 8'($urandom);
        if (b_rand) mem_b = 8'($urandom);
    endtask

    function automatic int qcount(input int mode);
        case (mode)
            0:       return q_obs_a.size();
            1:       return q_obs_b.size();
            2:       return q_per_a.size();
            default: return q_per_b.size();
        endcase
    endfunction

    task automatic run_until(input int mode, input int n, input int div,
                             input int maxc, output bit to);
        int c;
        c  = 0;
        to = 1'b0;
        while (qcount(mode) < n) begin
            if (c >= maxc) begin
                to = 1'b1;
                break;
            end
            clk_step((c % div) == 0);
            c++;
        end
    endtask

    task automatic clear_queues();
        q_obs_a.delete(); q_exp_a.delete(); q_rise_a.delete(); q_addr_a.delete();
        q_obs_b.delete(); q_exp_b.delete(); q_rise_b.delete();
        q_per_a.delete(); q_per_b.delete();
    endtask

    task automatic randomize_mem();
        for (int d = 0; d < int'(NUM_DIGITS); d++) mem[d] = 8'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit to;
        int c;
        clear_queues();
        randomize_mem();
        rst_n = 1'b0;
        repeat (3) clk_step(1'b1);
        checks++;
        if ({ser_a, sclk_a, rclk_a, com_a, busy_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_a: outputs=%b expected=00000", {ser_a, sclk_a, rclk_a, com_a, busy_a});
        end
        checks++;
        if ({ser_b, sclk_b, rclk_b, com_b, busy_b} !== 5'b0) begin
            errors++;
            $display("FAIL reset_b: outputs=%b expected=00000", {ser_b, sclk_b, rclk_b, com_b, busy_b});
        end
        rst_n = 1'b1;
        clk_step(1'b0);
        checks++;
        if ({ser_a, sclk_a, rclk_a, com_a, busy_a} !== 5'b0) begin
            errors++;
            $display("FAIL idle_hold: outputs=%b expected=00000", {ser_a, sclk_a, rclk_a, com_a, busy_a});
        end
        clk_step(1'b1);
        checks++;
        if ({busy_a, sclk_a, rclk_a, com_a} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_to_load: busy/sclk/rclk/com=%b expected=1000", {busy_a, sclk_a, rclk_a, com_a});
        end
        clk_step(1'b1);
        checks++;
        if (ser_a !== mem[0][7] || sclk_a !== 1'b0) begin
            errors++;
            $display("FAIL load_first_bit: ser=%b sclk=%b expected ser=%b sclk=0", ser_a, sclk_a, mem[0][7]);
        end
        // go to the middle of SHIFT_HI with a partially shifted pattern
        c = 0;
        while (!(sclk_a === 1'b1 && rise_a >= 2) && c < 40) begin
            clk_step(1'b1);
            c++;
        end
        checks++;
        if (c >= 40) begin
            errors++;
            $display("FAIL reach_shift_hi: timeout after %0d clocks", c);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ser_a, sclk_a, rclk_a, com_a, busy_a} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: outputs=%b expected=00000", {ser_a, sclk_a, rclk_a, com_a, busy_a});
        end
        clk_step(1'b1);
        clk_step(1'b1);
        checks++;
        if (q_obs_a.size() != 0) begin
            errors++;
            $display("FAIL no_partial_latch: latches=%0d expected=0", q_obs_a.size());
        end
        rst_n = 1'b1;
        run_until(0, 1, 1, 60, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL post_reset_frame_timeout: frames=%0d expected=1", q_obs_a.size());
        end else begin
            checks++;
            if (q_rise_a[0] != 8) begin
                errors++;
                $display("FAIL post_reset_rises: got=%0d expected=8", q_rise_a[0]);
            end
            checks++;
            if (q_obs_a[0] !== q_exp_a[0]) begin
                errors++;
                $display("FAIL post_reset_frame: got=%h expected=%h", q_obs_a[0], q_exp_a[0]);
            end
        end
    endtask

    task automatic test_msb_shift();
        bit to;
        for (int d = 0; d < int'(NUM_DIGITS); d++) mem[d] = 8'hA5;
        clear_queues();
        run_until(0, 3, 1, 200, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL a5_timeout: frames=%0d expected=3", q_obs_a.size());
        end else begin
            checks++;
            if (q_obs_a[2] !== 8'hA5) begin
                errors++;
                $display("FAIL a5_bits: shifted=%h expected=a5", q_obs_a[2]);
            end
        end
        randomize_mem();
        glitch_on = 1'b1;
        stab_a    = 0;
        clear_queues();
        run_until(0, 6, 1, 400, to);
        glitch_on = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL msb_rand_timeout: frames=%0d expected=6", q_obs_a.size());
        end
        foreach (q_obs_a[i]) begin
            checks++;
            if (q_obs_a[i] !== q_exp_a[i] || q_rise_a[i] != 8) begin
                errors++;
                $display("FAIL msb_frame[%0d]: got=%h rises=%0d expected=%h rises=8", i, q_obs_a[i], q_rise_a[i], q_exp_a[i]);
            end
        end
        foreach (q_per_a[i]) begin
            checks++;
            if (q_per_a[i] != PER_A) begin
                errors++;
                $display("FAIL period_cont[%0d]: got=%0d expected=%0d", i, q_per_a[i], PER_A);
            end
        end
        checks++;
        if (stab_a != 0) begin
            errors++;
            $display("FAIL ser_stable_a: changes_at_sclk_rise=%0d expected=0", stab_a);
        end
    endtask

    task automatic test_lsb_inv();
        bit to;
        mem_b  = 8'h01;
        b_rand = 1'b0;
        clear_queues();
        run_until(1, 2, 1, 200, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL lsb_timeout: frames=%0d expected=2", q_obs_b.size());
        end else begin
            // bits 0,1,1,1,1,1,1,1 shifted into an MSB-first register
            checks++;
            if (q_obs_b[1] !== 8'h7F) begin
                errors++;
                $display("FAIL lsb_inv_01: shifted=%h expected=7f", q_obs_b[1]);
            end
        end
        b_rand = 1'b1;
        stab_b = 0;
        clear_queues();
        run_until(1, 5, 1, 300, to);
        b_rand = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL lsb_rand_timeout: frames=%0d expected=5", q_obs_b.size());
        end
        foreach (q_obs_b[i]) begin
            checks++;
            if (q_obs_b[i] !== q_exp_b[i] || q_rise_b[i] != 8) begin
                errors++;
                $display("FAIL lsb_frame[%0d]: got=%h rises=%0d expected=%h rises=8", i, q_obs_b[i], q_rise_b[i], q_exp_b[i]);
            end
        end
        foreach (q_per_b[i]) begin
            checks++;
            if (q_per_b[i] != PER_B) begin
                errors++;
                $display("FAIL period_b[%0d]: got=%0d expected=%0d", i, q_per_b[i], PER_B);
            end
        end
        checks++;
        if (stab_b != 0) begin
            errors++;
            $display("FAIL ser_stable_b: changes_at_sclk_rise=%0d expected=0", stab_b);
        end
    endtask

    task automatic test_handshake();
        bit to;
        randomize_mem();
        glitch_on = 1'b1;
        clear_queues();
        run_until(2, 8, 4, 8 * PER_A * 4 + 400, to);
        glitch_on = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL handshake_timeout: periods=%0d expected=8", q_per_a.size());
        end
        foreach (q_per_a[i]) begin
            checks++;
            if (q_per_a[i] != PER_A) begin
                errors++;
                $display("FAIL hs_period[%0d]: got=%0d expected=%0d", i, q_per_a[i], PER_A);
            end
        end
        foreach (q_obs_a[i]) begin
            checks++;
            if (q_obs_a[i] !== q_exp_a[i]) begin
                errors++;
                $display("FAIL hs_frame[%0d]: got=%h expected=%h", i, q_obs_a[i], q_exp_a[i]);
            end
            if (i > 0) begin
                checks++;
                if (q_addr_a[i] != (q_addr_a[i - 1] + 1) % int'(NUM_DIGITS)) begin
                    errors++;
                    $display("FAIL hs_addr[%0d]: got=%0d expected=%0d", i, q_addr_a[i], (q_addr_a[i - 1] + 1) % int'(NUM_DIGITS));
                end
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        int chg;
        logic [4:0] snap;
        clear_queues();
        run_until(0, 1, 1, 60, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL stall_sync_timeout: frames=%0d expected=1", q_obs_a.size());
        end
        repeat (4) clk_step(1'b1);
        snap = {ser_a, sclk_a, rclk_a, com_a, busy_a};
        q_per_a.delete();
        glitch_on = 1'b1;
        chg = 0;
        for (int i = 0; i < 100; i++) begin
            clk_step(1'b0);
            if ({ser_a, sclk_a, rclk_a, com_a, busy_a} !== snap) chg++;
        end
        glitch_on = 1'b0;
        checks++;
        if (chg != 0) begin
            errors++;
            $display("FAIL stall_hold: changed_clocks=%0d expected=0", chg);
        end
        run_until(2, 2, 1, 200, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL stall_resume_timeout: periods=%0d expected=2", q_per_a.size());
        end else begin
            checks++;
            if (q_per_a[0] != PER_A || q_per_a[1] != PER_A) begin
                errors++;
                $display("FAIL stall_resume: periods=%0d,%0d expected=%0d", q_per_a[0], q_per_a[1], PER_A);
            end
        end
    endtask

`ifdef SEG_BLANK_EN
    task automatic test_blank();
        bit to;
        for (int d = 0; d < int'(NUM_DIGITS); d++) mem[d] = 8'hFF;
        mem_b = 8'hFF;
        run_until(2, 1, 1, 100, to);
        disp_on = 1'b0;
        clear_queues();
        run_until(2, 3, 2, 3 * PER_A * 2 + 200, to);
        disp_on = 1'b1;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL blank_timeout: periods=%0d expected=3", q_per_a.size());
        end
        foreach (q_obs_a[i]) begin
            if (i > 0) begin
                checks++;
                if (q_obs_a[i] !== 8'h00) begin
                    errors++;
                    $display("FAIL blank_a[%0d]: shifted=%h expected=00", i, q_obs_a[i]);
                end
            end
        end
        foreach (q_obs_b[i]) begin
            if (i > 0) begin
                checks++;
                if (q_obs_b[i] !== 8'hFF) begin
                    errors++;
                    $display("FAIL blank_b[%0d]: shifted=%h expected=ff", i, q_obs_b[i]);
                end
            end
        end
        foreach (q_per_a[i]) begin
            checks++;
            if (q_per_a[i] != PER_A) begin
                errors++;
                $display("FAIL blank_period[%0d]: got=%0d expected=%0d", i, q_per_a[i], PER_A);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < int'(NUM_DIGITS); d++) mem[d] = seg_glyph(4'(d));
        test_reset();
        test_msb_shift();
        test_lsb_inv();
        test_handshake();
        test_stall();
`ifdef SEG_BLANK_EN
        test_blank();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
